// File: rtl/compare_pkg.sv
// compare_pkg: shared constants and types for the shared compare arbiter.
//   CMP_N_DEF    - default operand width
//   CMP_NREQ_DEF - default requester count
//   cmp_result_t - one-hot Less/More/Equal result held in the output register
package compare_pkg;

   localparam int CMP_N_DEF    = 16;
   localparam int CMP_NREQ_DEF = 4;

   typedef struct packed {
      logic less;
      logic more;
      logic equal;
   } cmp_result_t;

endpackage

// File: rtl/mag_compare.sv
// mag_compare: purely combinational N-bit unsigned magnitude comparator.
//   x, y   in  N  operands (unsigned)
//   less   out 1  x < y
//   more   out 1  x > y
//   equal  out 1  x == y
module mag_compare #(
   parameter int N = 16
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic         less,
   output logic         more,
   output logic         equal
);

   assign less  = (x < y);
   assign more  = (x > y);
   assign equal = (x == y);

endmodule

// File: rtl/shared_compare_arbiter.sv
// shared_compare_arbiter: round-robin arbiter sharing one magnitude comparator
// among NREQ requesters, with a single-entry backpressured result register.
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   per-requester job handshake (ready is one-hot or zero)
//   req_x, req_y      packed operands, requester i in bits [i*N +: N]
//   rsp_valid/ready   result register handshake
//   rsp_id            requester that owns the held result
//   rsp_less/more/equal  registered unsigned compare flags
//   grant_count       saturating count of accepted jobs
module shared_compare_arbiter
   import compare_pkg::*;
#(
   parameter  int N    = CMP_N_DEF,
   parameter  int NREQ = CMP_NREQ_DEF,
   localparam int ID_W = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*N-1:0] req_x,
   input  logic [NREQ*N-1:0] req_y,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ID_W-1:0]   rsp_id,
   output logic              rsp_less,
   output logic              rsp_more,
   output logic              rsp_equal,
   output logic [15:0]       grant_count
);

   // Doubled request vector; the top copy omits its MSB since a search
   // starting at rr_ptr never reaches past index 2*NREQ-2.
   localparam int DW = 2*NREQ-1;

   logic              rsp_valid_q, rsp_valid_d;
   cmp_result_t       res_q, res_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]       cnt_q, cnt_d;

   logic [DW-1:0]     dbl;
   logic              free, found, handshake;
   logic [ID_W-1:0]   gnt_idx;
   logic [N-1:0]      sel_x, sel_y;
   cmp_result_t       cmp_res;

   assign dbl  = {req_valid[NREQ-2:0], req_valid};
   assign free = !rsp_valid_q || rsp_ready;

   // Priority encode from rr_ptr upward; the doubled vector handles the wrap.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         int p;
         p = int'(rr_ptr_q) + k;
         if (!found && ((dbl >> p) & DW'(1)) != '0) begin
            found   = 1'b1;
            gnt_idx = ID_W'((p >= NREQ) ? p - NREQ : p);
         end
      end
   end

   // rst_n gating keeps req_ready low while reset is held, even though
   // the empty register would otherwise look free.
   assign handshake = free && found && rst_n;
   assign req_ready = handshake ? (NREQ'(1) << gnt_idx) : '0;

   // Operand mux into the single shared comparator.
   always_comb begin
      sel_x = '0;
      sel_y = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_x = req_x[i*N +: N];
            sel_y = req_y[i*N +: N];
         end
      end
   end

   mag_compare #(.N(N)) u_cmp (
      .x     (sel_x),
      .y     (sel_y),
      .less  (cmp_res.less),
      .more  (cmp_res.more),
      .equal (cmp_res.equal)
   );

   // A load takes priority over a drain, so drain+load keeps rsp_valid high.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      res_d       = res_q;
      id_d        = id_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      if (handshake) begin
         rsp_valid_d = 1'b1;
         res_d       = cmp_res;
         id_d        = gnt_idx;
         rr_ptr_d    = (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + ID_W'(1);
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         res_q       <= '0;
         id_q        <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         res_q       <= res_d;
         id_q        <= id_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = id_q;
   assign rsp_less    = res_q.less;
   assign rsp_more    = res_q.more;
   assign rsp_equal   = res_q.equal;
   assign grant_count = cnt_q;

endmodule

// File: tb/tb_shared_compare_arbiter.sv
// tb_shared_compare_arbiter: scoreboard bench for shared_compare_arbiter
// (N=16, NREQ=4). Expected results are queued at grant time and compared
// while the result is held and when it is consumed.
module tb_shared_compare_arbiter;

   localparam int N    = 16;
   localparam int NREQ = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*N-1:0] req_x, req_y;
   logic [NREQ-1:0]  req_ready;
   logic             rsp_valid, rsp_ready;
   logic [1:0]       rsp_id;
   logic             rsp_less, rsp_more, rsp_equal;
   logic [15:0]      grant_count;

   shared_compare_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_less(rsp_less), .rsp_more(rsp_more), .rsp_equal(rsp_equal),
      .grant_count(grant_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic       l, m, e;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0;
   int     errors = 0;
   logic   m_valid = 1'b0;
   int     m_ptr = 0;
   int     m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs just after negedge, check, model the edge.
   task automatic cyc(input logic [3:0] v, input logic [63:0] xs,
                      input logic [63:0] ys, input logic rr);
      int   gi;
      logic [3:0] exp_rdy;
      exp_t e;
      req_valid = v; req_x = xs; req_y = ys; rsp_ready = rr;
      #1;
      gi = -1;
      exp_rdy = '0;
      if (!m_valid || rr) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (gi < 0 && v[i]) gi = i;
         end
      end
      if (gi >= 0) exp_rdy[gi] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("grant_count", grant_count, m_cnt);
      if (m_valid) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb[0];
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_flags", {rsp_less, rsp_more, rsp_equal}, {e.l, e.m, e.e});
            if (rr) void'(sb.pop_front());
         end
      end
      if (gi >= 0) begin
         logic [15:0] x, y;
         x = xs[gi*N +: N];
         y = ys[gi*N +: N];
         e.id = 2'(gi); e.l = x < y; e.m = x > y; e.e = x == y;
         sb.push_back(e);
         m_ptr = (gi + 1) % NREQ;
         if (m_cnt != 16'hFFFF) m_cnt++;
         m_valid = 1'b1;
      end else if (rr) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [63:0] xs, ys;
      rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
      #3;
      req_valid = 4'hF;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_flags", {rsp_less, rsp_more, rsp_equal}, 0);
      chk("rst_cnt", grant_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four valid: grants 0,1,2,3,0,1 back to back.
      for (int c = 0; c < 6; c++) begin
         xs = {16'd40, 16'd30, 16'd20, 16'd10};
         ys = {16'd40, 16'd10, 16'd25, 16'(c * 4)};
         cyc(4'hF, xs, ys, 1'b1);
      end
      cyc(4'h0, '0, '0, 1'b1);

      // Single job on requester 2: 5 vs 9.
      req_valid = 4'b0100; req_x = 64'(16'd5) << 32; req_y = 64'(16'd9) << 32;
      rsp_ready = 1'b1;
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      cyc(4'b0100, 64'(16'd5) << 32, 64'(16'd9) << 32, 1'b1);
      chk("t1_id", rsp_id, 2);
      chk("t1_flags", {rsp_less, rsp_more, rsp_equal}, 3'b100);

      // Pointer wrap: last grant 2, requesters 1 and 3 -> 3 then 1.
      xs = {16'd7, 16'd0, 16'd3, 16'd0};
      ys = {16'd7, 16'd0, 16'd1, 16'd0};
      cyc(4'b1010, xs, ys, 1'b1);
      chk("wrap_first", rsp_id, 3);
      cyc(4'b0010, xs, ys, 1'b1);
      chk("wrap_second", rsp_id, 1);

      // Boundary operands through requester 0.
      cyc(4'b0001, 64'hFFFF, 64'hFFFF, 1'b1);
      chk("bnd_eq", {rsp_less, rsp_more, rsp_equal}, 3'b001);
      cyc(4'b0001, 64'h0000, 64'hFFFF, 1'b1);
      chk("bnd_lt", {rsp_less, rsp_more, rsp_equal}, 3'b100);
      cyc(4'b0001, 64'hFFFF, 64'h0000, 1'b1);
      chk("bnd_gt", {rsp_less, rsp_more, rsp_equal}, 3'b010);
      cyc(4'b0001, 64'h8000, 64'h7FFF, 1'b1);
      chk("bnd_msb", {rsp_less, rsp_more, rsp_equal}, 3'b010);

      // Backpressure: hold 3 cycles with requesters 1 and 3 pending.
      xs = {16'd100, 16'd0, 16'd200, 16'd0};
      ys = {16'd50, 16'd0, 16'd300, 16'd0};
      for (int c = 0; c < 3; c++) cyc(4'b1010, xs, ys, 1'b0);
      cyc(4'b1010, xs, ys, 1'b1);
      chk("bp_grant1", rsp_id, 1);
      cyc(4'b1000, xs, ys, 1'b1);
      cyc(4'b0000, xs, ys, 1'b1);

      // Reset mid-operation while a result is held.
      cyc(4'b0100, {16'd0, 16'd9, 16'd0, 16'd0}, {16'd0, 16'd1, 16'd0, 16'd0}, 1'b0);
      chk("pre_rst_valid", rsp_valid, 1);
      req_valid = 4'hF;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_id", rsp_id, 0);
      chk("mid_rst_flags", {rsp_less, rsp_more, rsp_equal}, 0);
      chk("mid_rst_cnt", grant_count, 0);
      chk("mid_rst_ready", req_ready, 0);
      m_valid = 1'b0; m_ptr = 0; m_cnt = 0; sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(4'hF, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd2, 16'd3, 16'd1}, 1'b1);
      chk("post_rst_id", rsp_id, 0);
      chk("post_rst_cnt", grant_count, 1);
      cyc(4'h0, '0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end

endmodule
